// File: rtl/microcode_sequencer_pkg.sv
// Shared opcode, field-position and state definitions for the microcode sequencer.
// Also provides the branch-condition evaluation used at decode time.
package microcode_sequencer_pkg;

  localparam int UC_WORD_W   = 8;
  localparam int UC_CTRL_W   = 6;
  localparam int UC_OP_MSB   = 7;
  localparam int UC_OP_LSB   = 6;
  localparam int UC_COND_MSB = 5;
  localparam int UC_COND_LSB = 4;
  localparam int UC_INV_BIT  = 3;
  localparam int UC_T8_BIT   = 0;

  localparam logic [1:0] UC_OP_CTRL   = 2'b00;
  localparam logic [1:0] UC_OP_BRANCH = 2'b01;
  localparam logic [1:0] UC_OP_JUMP   = 2'b10;
  localparam logic [1:0] UC_OP_HALT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_FETCH_T  = 3'd3,
    ST_DECODE_T = 3'd4
  } uc_state_e;

  // JUMP is a BRANCH that is always taken; BRANCH selects one flag and may invert it.
  function automatic logic uc_branch_taken(input logic [UC_WORD_W-1:0] word,
                                           input logic [3:0]           cond);
    logic taken;
    if (word[UC_OP_MSB:UC_OP_LSB] == UC_OP_JUMP) begin
      taken = 1'b1;
    end else begin
      taken = cond[word[UC_COND_MSB:UC_COND_LSB]] ^ word[UC_INV_BIT];
    end
    return taken;
  endfunction

endpackage

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches words from a 1-cycle-latency store, decodes CTRL/BRANCH/JUMP/HALT
// and emits registered control fields. The address register doubles as the program counter.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  enable_in,
  input  logic                  start_in,
  input  logic [3:0]            cond_in,
  output logic [ADDR_WIDTH-1:0] uc_addr_out,
  input  logic [DATA_WIDTH-1:0] uc_data_in,
  output logic [DATA_WIDTH-3:0] ctrl_out,
  output logic                  ctrl_strobe_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  uc_state_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-3:0]   ctrl_q, ctrl_d;
  logic                    strobe_q, strobe_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    taken_q, taken_d;
  logic                    t8_q, t8_d;
  logic [1:0]              opcode_s;
  logic [ADDR_WIDTH-1:0]   target_s;

  assign opcode_s = uc_data_in[UC_OP_MSB:UC_OP_LSB];
  assign target_s = ADDR_WIDTH'({t8_q, uc_data_in});

  // State register
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a low enable_in holds the current state
  always_comb begin
    state_d = state_q;
    if (enable_in) begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) state_d = ST_FETCH;
          else          state_d = ST_IDLE;
        end
        ST_FETCH:    state_d = ST_DECODE;
        ST_DECODE: begin
          case (opcode_s)
            UC_OP_CTRL:               state_d = ST_FETCH;
            UC_OP_BRANCH, UC_OP_JUMP: state_d = ST_FETCH_T;
            UC_OP_HALT:               state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
          endcase
        end
        ST_FETCH_T:  state_d = ST_DECODE_T;
        ST_DECODE_T: state_d = ST_FETCH;
        default:     state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output/datapath next values; pulses default low so a frozen cycle drops them
  always_comb begin
    addr_d   = addr_q;
    ctrl_d   = ctrl_q;
    taken_d  = taken_q;
    t8_d     = t8_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    if (enable_in) begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) addr_d = START_ADDR;
          else          addr_d = addr_q;
        end
        ST_DECODE: begin
          case (opcode_s)
            UC_OP_CTRL: begin
              ctrl_d   = uc_data_in[UC_CTRL_W-1:0];
              strobe_d = 1'b1;
              addr_d   = addr_q + ADDR_ONE;
            end
            UC_OP_BRANCH, UC_OP_JUMP: begin
              taken_d = uc_branch_taken(uc_data_in, cond_in);
              t8_d    = uc_data_in[UC_T8_BIT];
              addr_d  = addr_q + ADDR_ONE;
            end
            UC_OP_HALT: done_d = 1'b1;
            default:    done_d = 1'b0;
          endcase
        end
        // Current uc_data_in is the target byte that follows the BRANCH/JUMP opcode
        ST_DECODE_T: begin
          if (taken_q) addr_d = target_s;
          else         addr_d = addr_q + ADDR_ONE;
        end
        default: addr_d = addr_q;
      endcase
    end else begin
      addr_d = addr_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      addr_q   <= START_ADDR;
      ctrl_q   <= {(DATA_WIDTH-2){1'b0}};
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      taken_q  <= 1'b0;
      t8_q     <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      ctrl_q   <= ctrl_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      taken_q  <= taken_d;
      t8_q     <= t8_d;
    end
  end

  assign uc_addr_out     = addr_q;
  assign ctrl_out        = ctrl_q;
  assign ctrl_strobe_out = strobe_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;

endmodule
